// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the tick-enable controller and anything that consumes tick enables.
package tick_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tick mode: continuous ticking or a single tick per start
    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Default ratios: ~1 Hz from a 50 MHz board clock, and a short ratio for simulation
    localparam int unsigned TICK_DEF_RATIO = 50000000;
    localparam int unsigned TICK_SIM_RATIO = 8;

endpackage

// File: rtl/tick_counter.sv
// Cycle counter with terminal-count compare; wraps to zero when it reaches term_i.
module tick_counter #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Terminal count is only meaningful while counting is enabled
    assign wrap_o = en_i && (cnt_q == term_i);

    // Next count: clear has priority, otherwise advance or wrap when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_ctrl.sv
// Programmable clock-enable controller: single-cycle tick every Neff cycles plus a toggled clkout.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 26,
    parameter int unsigned DEF_RATIO = TICK_DEF_RATIO,
    parameter int unsigned SIM       = 0,
    parameter int unsigned SIM_RATIO = TICK_SIM_RATIO
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_ratio,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             clkout,
    output logic [7:0]       tick_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             mode_q, mode_d;
    logic             busy_q, tick_q, tick_d;
    logic             clkout_q, clkout_d;
    logic [7:0]       tcount_q, tcount_d;

    logic             cfg_fire;
    logic [WIDTH-1:0] term;
    logic             cnt_clear, cnt_en, cnt_wrap;

    // Terminal count for a ratio; ratios 0 and 1 both mean "every cycle"
    function automatic logic [WIDTH-1:0] term_of(input logic [WIDTH-1:0] n);
        return (n == '0) ? '0 : n - WIDTH'(1);
    endfunction

    // Config is only writable outside RUN, so the counter never sees a mid-count ratio change
    assign cfg_ready = (state_q != RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign term      = term_of((SIM != 0) ? WIDTH'(SIM_RATIO) : ratio_q);

    tick_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clkin   (clkin),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .term_i  (term),
        .wrap_o  (cnt_wrap)
    );

    // Config latch: a handshake in the same cycle as start is used by that run
    always_comb begin
        ratio_d = ratio_q;
        mode_d  = mode_q;
        if (cfg_fire) begin
            ratio_d = cfg_ratio;
            mode_d  = cfg_mode;
        end
    end

    // Next-state and output logic; stop always wins over start and over a due tick
    always_comb begin
        state_d   = state_q;
        tick_d    = 1'b0;
        clkout_d  = clkout_q;
        tcount_d  = tcount_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                    clkout_d  = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_wrap) begin
                        tick_d   = 1'b1;
                        clkout_d = ~clkout_q;
                        tcount_d = tcount_q + 8'd1;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d   = RUN;
                    cnt_clear = 1'b1;
                    tcount_d  = 8'd0;
                    clkout_d  = 1'b0;
                end
            end
        endcase
    end

    // State, config and registered outputs
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q  <= IDLE;
            ratio_q  <= WIDTH'(DEF_RATIO);
            mode_q   <= MODE_CONT;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            clkout_q <= 1'b0;
            tcount_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            ratio_q  <= ratio_d;
            mode_q   <= mode_d;
            busy_q   <= (state_d == RUN);
            tick_q   <= tick_d;
            clkout_q <= clkout_d;
            tcount_q <= tcount_d;
        end
    end

    assign busy       = busy_q;
    assign tick       = tick_q;
    assign clkout     = clkout_q;
    assign tick_count = tcount_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed testbench for tick_ctrl: table-driven continuous run plus hand-written corner sequences.
module tb_tick_ctrl;

    logic        clkin = 1'b0;
    logic        reset;

    logic        cfg_valid, cfg_mode, start, stop;
    logic [25:0] cfg_ratio;
    logic        cfg_ready, busy, tick, clkout;
    logic [7:0]  tick_count;

    logic        s_cfg_valid, s_cfg_mode, s_start, s_stop;
    logic [25:0] s_cfg_ratio;
    logic        s_cfg_ready, s_busy, s_tick, s_clkout;
    logic [7:0]  s_tick_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clkin = ~clkin;

    tick_ctrl #(.WIDTH(26), .SIM(0)) dut (
        .clkin(clkin), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ratio(cfg_ratio), .cfg_mode(cfg_mode),
        .start(start), .stop(stop), .busy(busy), .tick(tick), .clkout(clkout),
        .tick_count(tick_count)
    );

    tick_ctrl #(.WIDTH(26), .SIM(1), .SIM_RATIO(8)) u_sim (
        .clkin(clkin), .reset(reset),
        .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready), .cfg_ratio(s_cfg_ratio), .cfg_mode(s_cfg_mode),
        .start(s_start), .stop(s_stop), .busy(s_busy), .tick(s_tick), .clkout(s_clkout),
        .tick_count(s_tick_count)
    );

    typedef struct {
        logic        cv;
        logic [25:0] ratio;
        logic        mode;
        logic        st;
        logic        sp;
        logic        e_tick;
        logic        e_busy;
        logic        e_ready;
        logic        e_clk;
        logic [7:0]  e_tc;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic cv, input logic [25:0] r, input logic m,
                                input logic st, input logic sp, input logic et, input logic eb,
                                input logic er, input logic ec, input logic [7:0] etc_v);
        vec_t v;
        v = '{cv, r, m, st, sp, et, eb, er, ec, etc_v};
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic et, input logic eb, input logic er,
                           input logic ec, input logic [7:0] etc_v);
        chk({tag, ".tick"}, tick, et);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".cfg_ready"}, cfg_ready, er);
        chk({tag, ".clkout"}, clkout, ec);
        chk({tag, ".tick_count"}, tick_count, etc_v);
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; cfg_ratio = '0; cfg_mode = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic cfg_start(input logic [25:0] r, input logic m);
        cfg_valid = 1'b1; cfg_ratio = r; cfg_mode = m; start = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        int nticks;
        reset = 1'b1;
        idle_inputs();
        s_cfg_valid = 1'b0; s_cfg_ratio = '0; s_cfg_mode = 1'b0; s_start = 1'b0; s_stop = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step();
        chk_all("reset_idle", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("sim_reset.busy", s_busy, 1'b0);
        chk("sim_reset.cfg_ready", s_cfg_ready, 1'b1);
        chk("sim_reset.tick_count", s_tick_count, 8'd0);

        // SIM instance: forced ratio 8
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("sim_start.busy", s_busy, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("sim.tick", s_tick, (k % 8 == 0));
            if (k % 8 == 0) begin
                chk("sim.clkout", s_clkout, (k / 8) % 2);
                chk("sim.tick_count", s_tick_count, k / 8);
            end
        end
        s_stop = 1'b1;
        step();
        s_stop = 1'b0;

        // Table: ratio 5 continuous, config attempts during RUN ignored, then restart with kept ratio
        add(1, 5, 0, 1, 0,  0, 1, 0, 0, 0);
        add(1, 3, 0, 0, 0,  0, 1, 0, 0, 0);
        add(1, 3, 0, 0, 0,  0, 1, 0, 0, 0);
        add(1, 3, 0, 1, 0,  0, 1, 0, 0, 0);
        add(1, 3, 0, 0, 0,  0, 1, 0, 0, 0);
        add(1, 3, 0, 0, 0,  1, 1, 0, 1, 1);
        add(1, 3, 0, 0, 0,  0, 1, 0, 1, 1);
        add(1, 3, 0, 0, 0,  0, 1, 0, 1, 1);
        add(1, 3, 0, 0, 0,  0, 1, 0, 1, 1);
        add(1, 3, 0, 0, 0,  0, 1, 0, 1, 1);
        add(1, 3, 0, 0, 0,  1, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 3);
        add(0, 0, 0, 0, 1,  0, 0, 1, 0, 3);
        add(0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1,  0, 0, 1, 0, 1);
        foreach (vq[i]) begin
            cfg_valid = vq[i].cv; cfg_ratio = vq[i].ratio; cfg_mode = vq[i].mode;
            start = vq[i].st; stop = vq[i].sp;
            step();
            chk_all("table", vq[i].e_tick, vq[i].e_busy, vq[i].e_ready, vq[i].e_clk, vq[i].e_tc);
        end
        idle_inputs();

        // One-shot, ratio 4
        cfg_valid = 1'b1; cfg_ratio = 26'd4; cfg_mode = 1'b1;
        step();
        idle_inputs();
        chk("os_cfg.busy", busy, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("os_start.busy", busy, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("os_wait.tick", tick, 1'b0);
            chk("os_wait.busy", busy, 1'b1);
        end
        step();
        chk_all("os_tick", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        nticks = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick) nticks++;
        end
        chk("os_done.extra_ticks", nticks, 0);
        chk("os_done.busy", busy, 1'b0);
        chk("os_done.tick_count", tick_count, 8'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("os_restart", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("os_rewait.tick", tick, 1'b0);
        end
        step();
        chk_all("os_retick", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);

        // Ratios 0 and 1: tick every cycle
        for (int r = 0; r <= 1; r++) begin
            cfg_start(26'(r), 1'b0);
            chk("fast_start.busy", busy, 1'b1);
            for (int k = 1; k <= 6; k++) begin
                step();
                chk("fast.tick", tick, 1'b1);
                chk("fast.clkout", clkout, k % 2);
                chk("fast.tick_count", tick_count, k);
            end
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk_all("fast_stop", 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
        end

        // Stop in the cycle where cnt == Neff-1 suppresses the tick
        cfg_start(26'd6, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("coll_wait.tick", tick, 1'b0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all("coll_stop", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b1; stop = 1'b1;
        step();
        idle_inputs();
        chk("startstop.busy", busy, 1'b0);
        step();
        chk("startstop_after.busy", busy, 1'b0);

        // Reset mid-RUN restores the default ratio
        cfg_start(26'd10, 1'b0);
        for (int k = 1; k <= 7; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("midrun_reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("def_start.busy", busy, 1'b1);
        nticks = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick) nticks++;
        end
        chk("def_ratio.ticks", nticks, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // tick_count wraps modulo 256
        cfg_start(26'd1, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 255) chk("wrap.tc255", tick_count, 8'd255);
            if (k == 256) chk("wrap.tc256", tick_count, 8'd0);
            if (k == 300) chk("wrap.tc300", tick_count, 8'd44);
        end
        chk("wrap.busy", busy, 1'b1);
        stop = 1'b1;
        step();
        stop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
